pp_pipeline_accel_fifo_to_axis: RTL

- Read-side drain engine for the accelerator's HLS-style handshake FIFOs (empty_n/read/dout, first-word-fall-through head).
- Pops exactly frame_len words per started frame and emits them on an AXI4-Stream master, asserting tlast on the final beat.
- Decouples FIFO pop from downstream backpressure with a registered 2-entry output buffer; there is no combinational path from m_tready to fifo_read.
- Sits between pipeline-stage output FIFOs and the stream interconnect/DMA.

---
 rtl/pp_pipeline_accel_fifo_to_axis.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pp_pipeline_accel_fifo_to_axis.sv
// pp_pipeline_accel_fifo_to_axis
// Drains exactly frame_len words per frame from an HLS-style FWFT handshake
// FIFO (empty_n/read/dout) and emits them as an AXI4-Stream frame with tlast
// on the final beat. A registered 2-entry skid buffer sits between the FIFO
// pop and the stream, so fifo_read never depends on m_tready.
//
// Optional build macro: PP_FIFO2AXIS_STATS_EN adds saturating 32-bit
// stat_frames / stat_stall counters as extra outputs.
//
// Handshake semantics: a beat transfers on a rising edge where
// m_tvalid & m_tready are both high; once m_tvalid rises, m_tvalid, m_tdata
// and m_tlast hold until that transfer. A FIFO word is consumed on a rising
// edge where fifo_read is high (fifo_read is only raised while fifo_empty_n).
module pp_pipeline_accel_fifo_to_axis #(
    parameter int DATA_WIDTH = 5,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic [1:0]            state_dbg
`ifdef PP_FIFO2AXIS_STATS_EN
    ,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic [1:0]            cnt_q;
    logic [DATA_WIDTH-1:0] head_data_q;
    logic                  head_last_q;
    logic [DATA_WIDTH-1:0] tail_data_q;
    logic                  tail_last_q;
    logic                  done_q;

    logic                  push;
    logic                  push_last;
    logic                  pop;
    logic                  accept_start;
    logic                  zero_start;

    assign push         = fifo_read;
    assign push_last    = (issued_q == (len_q - LEN_WIDTH'(1)));
    assign pop          = (cnt_q != 2'd0) && m_tready;
    assign accept_start = (state_q == S_IDLE) && start && (frame_len != '0);
    assign zero_start   = (state_q == S_IDLE) && start && (frame_len == '0);

    assign m_tvalid  = (cnt_q != 2'd0);
    assign m_tdata   = head_data_q;
    assign m_tlast   = head_last_q;
    assign done      = done_q;
    assign state_dbg = state_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the last pop hands over to DRAIN on the same edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept_start)         state_d = S_STREAM;
            S_STREAM: if (push && push_last)    state_d = S_DRAIN;
            S_DRAIN:  if (pop && head_last_q)   state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Output logic: pop strobe uses only registered state and fifo_empty_n
    always_comb begin
        busy      = (state_q != S_IDLE);
        fifo_read = (state_q == S_STREAM) && fifo_empty_n &&
                    (cnt_q < 2'd2) && (issued_q < len_q);
    end

    // Frame bookkeeping: length latched at start, words issued counted per pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q    <= '0;
            issued_q <= '0;
        end else if (accept_start) begin
            len_q    <= frame_len;
            issued_q <= '0;
        end else if (push) begin
            issued_q <= issued_q + LEN_WIDTH'(1);
        end
    end

    // Two-entry output buffer; head entry drives the stream directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= 2'd0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_data_q <= fifo_dout;
                        head_last_q <= push_last;
                    end else begin
                        tail_data_q <= fifo_dout;
                        tail_last_q <= push_last;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    if (cnt_q == 2'd2) begin
                        head_data_q <= tail_data_q;
                        head_last_q <= tail_last_q;
                    end
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // push only happens with cnt<2, so cnt is 1 here
                    head_data_q <= fifo_dout;
                    head_last_q <= push_last;
                end
                default: ;
            endcase
        end
    end

    // Completion pulse: tlast accepted, or a zero-length start in IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= zero_start || ((state_q == S_DRAIN) && pop && head_last_q);
        end
    end

`ifdef PP_FIFO2AXIS_STATS_EN
    logic [31:0] frames_q;
    logic [31:0] stall_q;

    assign stat_frames = frames_q;
    assign stat_stall  = stall_q;

    // Saturating observation counters, off the datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frames_q <= '0;
            stall_q  <= '0;
        end else begin
            if (done_q && (frames_q != 32'hFFFF_FFFF)) begin
                frames_q <= frames_q + 32'd1;
            end
            if (m_tvalid && !m_tready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end
`endif

endmodule
